// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller and its line store.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_pkg;

  // Controller states: idle lookup, waiting on a bus read, waiting on a bus write.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  // Default addr[31:28] value that marks the uncached MMIO window.
  localparam logic [3:0] UNCACHED_HI_DEFAULT = 4'hF;

  // Request captured when a miss, uncached access or write leaves IDLE.
  // The word address is kept rather than the byte address; addr[1:0] is never used.
  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] wdata;
  } req_t;

  // True when a word address falls inside the uncached window.
  function automatic logic in_uncached(input logic [29:0] waddr, input logic [3:0] hi);
    return waddr[29:26] == hi;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Direct-mapped one-word line store: valid bits, tags and data.
// Latency: combinational read, write visible after the next rising edge.
// Backpressure: none; a write is accepted every cycle wr_en is high.
module dcache_array #(
  parameter int LINES = 16,
  parameter int IDX_W = 4,
  parameter int TAG_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_vld,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_dat,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_dat
);

  logic [LINES-1:0] vld_q;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [31:0]      dat_q [LINES];

  // Valid bits are the only reset state; a write always leaves its line valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else if (wr_en) begin
      vld_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and data payload; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx] <= wr_tag;
      dat_q[wr_idx] <= wr_dat;
    end
  end

  assign rd_vld = vld_q[rd_idx];
  assign rd_tag = tag_q[rd_idx];
  assign rd_dat = dat_q[rd_idx];

endmodule

// File: rtl/dmem_ctrl.sv
// Write-through, no-write-allocate direct-mapped data cache in front of a request/ack bus.
// Latency: read hit completes in the request cycle; misses, uncached reads and writes complete on bus_ack.
// Backpressure: one request outstanding; req_pulse is ignored while a bus transaction is in flight.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int         LINES       = 16,
  parameter logic [3:0] UNCACHED_HI = UNCACHED_HI_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_pulse,
  input  logic        rw,
  input  logic [31:0] addr,
  input  logic [31:0] data_write,
  output logic [31:0] data_read,
  output logic        dack,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - IDX_W;

  state_t state_q, state_d;
  req_t   lat_q, lat_d;

  // Byte offset within the word has no meaning for word-only accesses.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[1:0];

  // One lookup port serves both the live request (IDLE) and the latched
  // request (wait states), so the write-hit check uses the captured address.
  logic [29:0]      lk_word;
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_cached;
  logic             lk_hit;

  logic             rd_vld;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_dat;
  logic             wr_en;
  logic [31:0]      wr_dat;

  assign lk_word   = (state_q == IDLE) ? addr[31:2] : lat_q.waddr;
  assign lk_idx    = lk_word[IDX_W-1:0];
  assign lk_tag    = lk_word[29 -: TAG_W];
  assign lk_cached = !in_uncached(lk_word, UNCACHED_HI);
  assign lk_hit    = lk_cached && rd_vld && (rd_tag == lk_tag);

  dcache_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .rd_idx (lk_idx),
    .rd_vld (rd_vld),
    .rd_tag (rd_tag),
    .rd_dat (rd_dat),
    .wr_en  (wr_en),
    .wr_idx (lk_idx),
    .wr_tag (lk_tag),
    .wr_dat (wr_dat)
  );

  // State and request latch; reset abandons any in-flight bus transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
    end
  end

  // Next state, completion/bus outputs and line-store write strobe.
  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    dack      = 1'b0;
    data_read = '0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    wr_en     = 1'b0;
    wr_dat    = '0;

    case (state_q)
      IDLE: begin
        // bus_ack here is a stray and is deliberately not looked at.
        if (req_pulse) begin
          if (rw && lk_hit) begin
            dack      = 1'b1;
            data_read = rd_dat;
          end else begin
            lat_d.waddr = addr[31:2];
            lat_d.wdata = data_write;
            state_d     = rw ? RD_WAIT : WR_WAIT;
          end
        end
      end

      RD_WAIT: begin
        bus_req  = 1'b1;
        bus_addr = {lat_q.waddr, 2'b00};
        if (bus_ack) begin
          dack      = 1'b1;
          data_read = bus_rdata;
          wr_en     = lk_cached;
          wr_dat    = bus_rdata;
          state_d   = IDLE;
        end
      end

      WR_WAIT: begin
        bus_req   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = {lat_q.waddr, 2'b00};
        bus_wdata = lat_q.wdata;
        if (bus_ack) begin
          dack    = 1'b1;
          wr_en   = lk_hit;
          wr_dat  = lat_q.wdata;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Keep completion and store writes quiet for the whole reset window.
    if (rst) begin
      dack      = 1'b0;
      data_read = '0;
      wr_en     = 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a word-addressed reference model and per-cycle output compare.
// Latency: n/a.
// Backpressure: n/a.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_pulse;
  logic        rw;
  logic [31:0] addr;
  logic [31:0] data_write;
  logic [31:0] data_read;
  logic        dack;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  always #5 clk = ~clk;

  dmem_ctrl #(
    .LINES       (16),
    .UNCACHED_HI (4'hF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_pulse  (req_pulse),
    .rw         (rw),
    .addr       (addr),
    .data_write (data_write),
    .data_read  (data_read),
    .dack       (dack),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_ack    (bus_ack)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one pending transaction plus a direct-mapped store keyed by word address.
  bit          m_busy = 0;
  bit          m_rd   = 0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  bit          ln_vld [16];
  logic [29:0] ln_word [16];
  logic [31:0] ln_dat [16];

  // Observation counters used by the directed literal checks.
  int          bus_cyc  = 0;
  int          dack_cnt = 0;
  logic [31:0] last_data = '0;
  logic [31:0] last_baddr = '0;
  logic        last_bwe = 1'b0;

  // Compare every cycle on the falling edge, then advance the model to the next rising edge.
  always @(negedge clk) begin : compare
    logic        e_dack, e_breq, e_bwe;
    logic [31:0] e_data, e_baddr, e_bwdata;
    int          idx;
    bit          cached, hit;
    e_dack = 0; e_breq = 0; e_bwe = 0;
    e_data = '0; e_baddr = '0; e_bwdata = '0;
    if (rst) begin
      m_busy = 0;
      for (int i = 0; i < 16; i++) ln_vld[i] = 0;
    end else if (!m_busy) begin
      if (req_pulse) begin
        idx    = (addr >> 2) % 16;
        cached = (addr[31:28] != 4'hF);
        hit    = cached && ln_vld[idx] && (ln_word[idx] == addr[31:2]);
        if (rw && hit) begin
          e_dack = 1;
          e_data = ln_dat[idx];
        end else begin
          m_busy  = 1;
          m_rd    = rw;
          m_addr  = addr;
          m_wdata = data_write;
        end
      end
    end else begin
      e_breq   = 1;
      e_bwe    = !m_rd;
      e_baddr  = m_addr & 32'hFFFF_FFFC;
      e_bwdata = m_rd ? 32'h0 : m_wdata;
      if (bus_ack) begin
        e_dack = 1;
        e_data = m_rd ? bus_rdata : 32'h0;
        idx    = (m_addr >> 2) % 16;
        cached = (m_addr[31:28] != 4'hF);
        if (cached && m_rd) begin
          ln_vld[idx]  = 1;
          ln_word[idx] = m_addr[31:2];
          ln_dat[idx]  = bus_rdata;
        end else if (cached && ln_vld[idx] && ln_word[idx] == m_addr[31:2]) begin
          ln_dat[idx] = m_wdata;
        end
        m_busy = 0;
      end
    end
    chk("dack", {31'b0, dack}, {31'b0, e_dack});
    chk("data_read", data_read, e_data);
    chk("bus_req", {31'b0, bus_req}, {31'b0, e_breq});
    chk("bus_we", {31'b0, bus_we}, {31'b0, e_bwe});
    chk("bus_addr", bus_addr, e_baddr);
    if (!(e_breq && !e_bwe)) chk("bus_wdata", bus_wdata, e_bwdata);
    if (dack === 1'b1) begin
      dack_cnt++;
      last_data = data_read;
    end
    if (bus_req === 1'b1) begin
      bus_cyc++;
      last_baddr = bus_addr;
      last_bwe   = bus_we;
    end
  end

  task automatic clr();
    bus_cyc = 0; dack_cnt = 0; last_data = '0; last_baddr = '0; last_bwe = 1'b0;
  endtask

  // One access: request pulse, then if the bus is requested, ack after lat bus_req cycles.
  // With noise set, a conflicting request is held on the pins during the wait.
  task automatic acc(input bit r, input logic [31:0] a, input logic [31:0] wd,
                     input int lat, input logic [31:0] rd, input bit noise);
    clr();
    @(posedge clk); #1;
    req_pulse = 1'b1; rw = r; addr = a; data_write = wd;
    @(posedge clk); #1;
    req_pulse = 1'b0; addr = ~a; data_write = 32'hA5A5_5A5A;
    if (bus_req === 1'b1) begin
      if (noise) begin
        req_pulse = 1'b1; rw = 1'b0; addr = 32'h0000_0200;
      end
      for (int i = 1; i < lat; i++) begin
        @(posedge clk); #1;
      end
      bus_ack = 1'b1; bus_rdata = rd;
      @(posedge clk); #1;
      bus_ack = 1'b0; bus_rdata = '0; req_pulse = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; req_pulse = 1'b0; rw = 1'b0; addr = '0; data_write = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    for (int i = 0; i < 16; i++) begin
      ln_vld[i] = 0; ln_word[i] = '0; ln_dat[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Cold read miss with three-cycle bus latency, then the same read hits.
    acc(1, 32'h0000_0040, 0, 3, 32'hDEAD_BEEF, 0);
    chk("miss_buscyc", bus_cyc, 3);
    chk("miss_dacks", dack_cnt, 1);
    chk("miss_data", last_data, 32'hDEAD_BEEF);
    chk("miss_baddr", last_baddr, 32'h0000_0040);
    acc(1, 32'h0000_0040, 0, 1, 0, 0);
    chk("hit_buscyc", bus_cyc, 0);
    chk("hit_data", last_data, 32'hDEAD_BEEF);

    // Write hit goes through to the bus and updates the line.
    acc(0, 32'h0000_0040, 32'h1234_5678, 2, 0, 0);
    chk("wr_buscyc", bus_cyc, 2);
    chk("wr_we", {31'b0, last_bwe}, 1);
    chk("wr_baddr", last_baddr, 32'h0000_0040);
    chk("wr_dacks", dack_cnt, 1);
    chk("wr_data_zero", last_data, 0);
    acc(1, 32'h0000_0040, 0, 1, 0, 0);
    chk("wrhit_rd_buscyc", bus_cyc, 0);
    chk("wrhit_rd_data", last_data, 32'h1234_5678);

    // Write miss does not allocate; the following read still goes to the bus.
    acc(0, 32'h0000_0080, 32'h0BAD_F00D, 1, 0, 0);
    chk("wrmiss_buscyc", bus_cyc, 1);
    acc(1, 32'h0000_0080, 0, 2, 32'hCAFE_0080, 0);
    chk("rd80_buscyc", bus_cyc, 2);
    chk("rd80_data", last_data, 32'hCAFE_0080);

    // Uncached reads always use the bus and never fill.
    acc(1, 32'hF000_0000, 0, 1, 32'h1, 0);
    chk("unc1_buscyc", bus_cyc, 1);
    chk("unc1_data", last_data, 32'h1);
    acc(1, 32'hF000_0000, 0, 1, 32'h2, 0);
    chk("unc2_buscyc", bus_cyc, 1);
    chk("unc2_data", last_data, 32'h2);
    acc(1, 32'h0000_0080, 0, 1, 0, 0);
    chk("post_unc_hit_buscyc", bus_cyc, 0);
    chk("post_unc_hit_data", last_data, 32'hCAFE_0080);

    // Index conflict between 0x40 and 0x80: three bus reads, the last one refills 0x40.
    acc(1, 32'h0000_0040, 0, 1, 32'h11, 0);
    chk("conf1_buscyc", bus_cyc, 1);
    acc(1, 32'h0000_0080, 0, 1, 32'h22, 0);
    chk("conf2_buscyc", bus_cyc, 1);
    acc(1, 32'h0000_0040, 0, 1, 32'h33, 0);
    chk("conf3_buscyc", bus_cyc, 1);
    acc(1, 32'h0000_0040, 0, 1, 0, 0);
    chk("conf_hit_buscyc", bus_cyc, 0);
    chk("conf_hit_data", last_data, 32'h33);

    // Stray bus_ack while idle produces nothing.
    clr();
    @(posedge clk); #1 bus_ack = 1'b1; bus_rdata = 32'hFFFF_0000;
    @(posedge clk); #1 bus_ack = 1'b0; bus_rdata = '0;
    @(posedge clk); #1;
    chk("idle_ack_dacks", dack_cnt, 0);

    // Requests and pin changes during a wait are ignored.
    acc(1, 32'h0000_0104, 0, 3, 32'h5555_AAAA, 1);
    @(posedge clk); #1;
    chk("noise_dacks", dack_cnt, 1);
    chk("noise_buscyc", bus_cyc, 3);
    chk("noise_baddr", last_baddr, 32'h0000_0104);
    chk("noise_data", last_data, 32'h5555_AAAA);
    acc(1, 32'h0000_0104, 0, 1, 0, 0);
    chk("noise_hit_buscyc", bus_cyc, 0);

    // Reset in the middle of a read wait aborts it and clears the cache.
    clr();
    @(posedge clk); #1 req_pulse = 1'b1; rw = 1'b1; addr = 32'h0000_0100;
    @(posedge clk); #1 req_pulse = 1'b0;
    chk("rst_pre_busreq", {31'b0, bus_req}, 1);
    rst = 1'b1;
    #1;
    chk("rst_busreq_drop", {31'b0, bus_req}, 0);
    chk("rst_dack", {31'b0, dack}, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_no_dack", dack_cnt, 0);
    acc(1, 32'h0000_0100, 0, 1, 32'h77, 0);
    chk("rst_reread_buscyc", bus_cyc, 1);
    chk("rst_reread_data", last_data, 32'h77);
    acc(1, 32'h0000_0104, 0, 1, 32'h88, 0);
    chk("rst_cleared_buscyc", bus_cyc, 1);
    chk("rst_cleared_data", last_data, 32'h88);

    repeat (2) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter LINES, 16, number of direct-mapped one-word cache lines (power of two, 4..256).
REQ-002 SHALL have parameter UNCACHED_HI, 4'hF, value of addr[31:28] that selects the uncached MMIO region.
REQ-003 SHALL have ports:
  clk  in  1  single clock, all state on rising edge
  rst  in  1  reset, asynchronous, active-high
  req_pulse  in  1  request strobe from mem stage
  rw  in  1  1=read, 0=write
  addr  in  32  byte address, addr[1:0] ignored
  data_write  in  32  store data
  data_read  out  32  load data, valid when dack=1 for a read
  dack  out  1  one-cycle completion pulse
  bus_req  out  1  backing-bus request, held until bus_ack
  bus_we  out  1  backing-bus write enable
  bus_addr  out  32  word-aligned bus address ({addr[31:2],2'b00})
  bus_wdata  out  32  bus write data
  bus_rdata  in  32  bus read data, valid with bus_ack
  bus_ack  in  1  bus completion, one cycle
REQ-004 Clock SHALL be clk; reset SHALL be rst, asynchronous, active-high.

Function
REQ-005 Address split SHALL be index=addr[2+:log2(LINES)], tag=addr[31:2+log2(LINES)]; no byte enables, word accesses only.
REQ-006 Read hit (req_pulse, rw=1, cached region, valid and tag match) SHALL assert dack and drive data_read from the line combinationally in the same cycle; no bus activity; FSM stays IDLE.
REQ-007 Read miss or uncached read SHALL set dack=0 that cycle, latch addr/rw/data_write and enter RD_WAIT on the next edge.
REQ-008 In RD_WAIT, bus_req=1, bus_we=0, bus_addr from latch; in the cycle bus_ack=1: dack=1, data_read=bus_rdata combinationally, return to IDLE; cached reads SHALL fill the line (valid=1, tag, data) on that edge; uncached reads SHALL NOT fill.
REQ-009 Any write SHALL set dack=0 at request, latch, and enter WR_WAIT (write-through, no-write-allocate).
REQ-010 In WR_WAIT, bus_req=1, bus_we=1, bus_wdata=latched data; on bus_ack: dack=1, return to IDLE; if the latched cached address hits, the line data SHALL be updated on that edge; a miss SHALL NOT allocate.
REQ-011 FSM states SHALL be IDLE, RD_WAIT, WR_WAIT only; req_pulse outside IDLE SHALL be ignored.
REQ-012 Latched request SHALL be used throughout the wait; addr/data changes after req_pulse SHALL have no effect.
REQ-013 dack SHALL be exactly one cycle per accepted request; never asserted without a preceding accepted req_pulse.
REQ-014 bus_req SHALL be 0 in IDLE; bus_addr/bus_wdata/bus_we SHALL be 0 when bus_req=0.
REQ-015 data_read SHALL be 0 whenever dack=0 or the completed access is a write.
REQ-016 bus_ack in IDLE SHALL be ignored.
REQ-017 Uncached region accesses SHALL never read or modify cache state.

Reset
REQ-018 rst SHALL immediately force state=IDLE, all valid bits=0, latches=0, dack=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, data_read=0.
REQ-019 Reset during RD_WAIT/WR_WAIT SHALL abort the transaction with no dack and no line fill.
REQ-020 Tag/data arrays need not be reset; only valid bits are.

Structure
REQ-021 Package dmem_pkg SHALL hold the state enum (IDLE, RD_WAIT, WR_WAIT) and the UNCACHED_HI default constant.
REQ-022 Storage SHALL be a sub-module dcache_array (valid/tag/data, async read, sync write port, async clear of valid bits); the FSM and bus logic live in dmem_ctrl.

Verification
REQ-023 After reset, read 0x0000_0040, bus returns 0xDEADBEEF after 3 cycles -> bus_req high 3 cycles, dack+data_read=0xDEADBEEF on ack cycle; repeat read -> same-cycle dack, 0xDEADBEEF, no bus_req.
REQ-024 Write 0x1234_5678 to cached 0x40 (hit) -> bus_we=1, bus_addr=0x40 until ack, dack on ack; next read 0x40 hits returning 0x12345678.
REQ-025 Write to 0x0000_0080 (miss) then read 0x80 -> write does not allocate; read misses and goes to bus.
REQ-026 Read 0xF000_0000 twice, bus returns 0x1 then 0x2 -> both go to bus, data_read 0x1 then 0x2, no fill.
REQ-027 Conflict: read 0x40 then 0x80 (same index, LINES=16) then 0x40 -> three bus reads, third refills.
REQ-028 Assert rst mid RD_WAIT -> bus_req drops immediately, no dack, subsequent read of the same address misses.
